convert_fixed_to_float_seq: RTL
===============================

// Module: convert_fixed_to_float_seq
// PURPOSE
//  Sequential fixed-to-float converter: the inverse path of the float-to-fixed linearizer/normalizer.
//  Accepts a 32-bit two's-complement fixed-point word (binary point between bits 30 and 29, range [-2,2))
//  and produces an IEEE-754 single-precision word using an iterative one-bit-per-cycle normalizing shift.
//  Sits at the output of the estimation datapath, returning fixed-point results to the float domain.
// PARAMETERS
//  P     32   data width, fixed input and float output
//  W     8    exponent width
//  FRAC  30   fractional bits of the fixed input
//  BIAS  127  exponent bias
// PORTS
//  CLK       in   1   clock, rising edge
//  RST       in   1   synchronous, active-high reset
//  START     in   1   request; sampled only in IDLE
//  FIXED     in   32  fixed-point operand; sampled on the accepting edge
//  BUSY      out  1   high in every state except IDLE
//  READY     out  1   one-cycle pulse; FLOAT valid and stable from this cycle on
//  FLOAT     out  32  result; held until the next completion
//  SHIFT_CNT out  5   normalizing shifts used for the last result (debug)
// BEHAVIOUR
//  - Reset: state=IDLE; BUSY=0, READY=0, FLOAT=0, SHIFT_CNT=0, all internal registers 0.
//    RST mid-operation aborts the conversion at once; no READY is produced.
//  - FSM: IDLE -> ABS -> SHIFT -> PACK -> IDLE.
//    IDLE : START=1 -> latch FIXED into X, go to ABS. START=0 -> stay.
//    ABS  : sign<=X[31]; mag<=X[31] ? 0-X : X (32-bit unsigned; 0x80000000 -> mag 0x80000000);
//           cnt<=0; if X==0 -> zero flag, go to PACK; else -> SHIFT.
//    SHIFT: if mag[31] -> PACK; else mag<=mag<<1, cnt<=cnt+1, stay.
//    PACK : FLOAT<=result, SHIFT_CNT<=cnt, READY<=1 for this one cycle, go to IDLE.
//  - Result: zero -> 32'h0000_0000 (no -0).
//    Otherwise {sign, E, mag[30:8]} with E = BIAS+(P-1)-FRAC-cnt (=128-cnt for defaults, range 97..128).
//    Compute E at W+1 bits; no over/underflow is possible for the defaults.
//    Mantissa truncates toward zero; no rounding.
//  - Latency, counted from the START-sampling edge: READY goes high after 3+s edges, where s = leading zeros of mag (0..31).
//    Zero input takes 2 edges. Worst case is 34.
//  - START while BUSY is ignored, with no queueing.
//    START in the cycle READY is high is accepted, since the FSM is already in IDLE.
//  - FIXED may change freely once it has been sampled.
// STRUCTURE
//  - Shared package holds: BIAS, P, W, FRAC defaults, FSM state encoding (2-bit: IDLE/ABS/SHIFT/PACK),
//    and the zero-float constant.
//  - One sub-module: lz_shift_norm. It contains the mag/cnt registers and the shift-until-MSB loop,
//    with load/enable/done ports. The top module holds the FSM, ABS, and PACK.
// TESTING
//  1 FIXED=0x40000000 (+1.0), START pulse -> FLOAT=0x3F800000, SHIFT_CNT=1, READY 4 edges after START.
//  2 FIXED=0xC0000000 (-1.0) -> 0xBF800000; FIXED=0x60000000 (+1.5) -> 0x3FC00000.
//  3 FIXED=0x80000000 (-2.0) -> 0xC0000000, SHIFT_CNT=0, 3 edges.
//    FIXED=0x00000000 -> 0x00000000, 2 edges.
//  4 FIXED=0x00000001 (2^-30) -> 0x30800000, SHIFT_CNT=31, READY after 34 edges.
//  5 Second START while BUSY with different FIXED -> ignored; first result delivered exactly once.
//    START issued in the READY cycle -> accepted, and its result follows with the normal latency.
//  6 RST asserted during SHIFT -> next cycle BUSY=0, FLOAT=0, no READY.
//    A following START converts normally.

Source files
------------

// File: rtl/convert_fixed_to_float_seq_pkg.sv
// Shared constants, FSM encoding and helpers for the fixed-to-float converter.
package convert_fixed_to_float_seq_pkg;

    localparam int unsigned P    = 32;  // data width (fixed in, float out)
    localparam int unsigned W    = 8;   // exponent width
    localparam int unsigned FRAC = 30;  // fractional bits of the fixed input
    localparam int unsigned BIAS = 127; // exponent bias

    localparam int unsigned CntW = $clog2(P);

    // Exponent for an MSB-aligned magnitude with zero shifts, kept at W+1 bits.
    localparam logic [W:0] ExpBase = (W + 1)'(BIAS + P - 1 - FRAC);

    localparam logic [P-1:0] ZeroFloat = '0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAbs   = 2'd1,
        StShift = 2'd2,
        StPack  = 2'd3
    } state_e;

    // Two's-complement magnitude; the most negative value maps to itself as unsigned.
    function automatic logic [P-1:0] abs_mag(input logic [P-1:0] x);
        return x[P-1] ? (P'(0) - x) : x;
    endfunction

endpackage

// File: rtl/convert_fixed_to_float_seq_if.sv
// Request/result bundle between a client and the fixed-to-float converter.
interface convert_fixed_to_float_seq_if;
    import convert_fixed_to_float_seq_pkg::*;

    logic            start;
    logic [P-1:0]    fixed;
    logic            busy;
    logic            ready;
    logic [P-1:0]    float;
    logic [CntW-1:0] shift_cnt;

    modport master (
        output start,
        output fixed,
        input  busy,
        input  ready,
        input  float,
        input  shift_cnt
    );

    modport slave (
        input  start,
        input  fixed,
        output busy,
        output ready,
        output float,
        output shift_cnt
    );

endinterface

// File: rtl/convert_fixed_to_float_seq_lz_shift_norm.sv
// Iterative normalizer: shifts a magnitude left one bit per enabled cycle until its MSB is set,
// counting the shifts taken.
module lz_shift_norm #(
    parameter int unsigned Width = 32,
    parameter int unsigned CntW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_mag,
    input  logic             en,
    output logic [Width-1:0] mag,
    output logic [CntW-1:0]  cnt,
    output logic             done
);

    logic [Width-1:0] mag_q, mag_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    assign done = mag_q[Width-1];
    assign mag  = mag_q;
    assign cnt  = cnt_q;

    // Load resets the count; each enabled cycle without a set MSB shifts once.
    always_comb begin
        mag_d = mag_q;
        cnt_d = cnt_q;
        if (load) begin
            mag_d = load_mag;
            cnt_d = '0;
        end else if (en && !mag_q[Width-1]) begin
            mag_d = {mag_q[Width-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Magnitude and shift-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q <= '0;
            cnt_q <= '0;
        end else begin
            mag_q <= mag_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/convert_fixed_to_float_seq.sv
// Sequential fixed-point (Q1.30, two's complement) to IEEE-754 single-precision converter.
module convert_fixed_to_float_seq
    import convert_fixed_to_float_seq_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    convert_fixed_to_float_seq_if.slave  bus
);

    state_e          state_q, state_d;
    logic [P-1:0]    x_q;
    logic            sign_q;
    logic            zero_q;
    logic [P-1:0]    float_q;
    logic [CntW-1:0] shift_cnt_q;
    logic            ready_q;

    logic            norm_load;
    logic            norm_en;
    logic [P-1:0]    norm_mag;
    logic [CntW-1:0] norm_cnt;
    logic            norm_done;

    logic [W:0]      exp_full;
    logic [P-1:0]    result;
    logic            unused_bits;

    lz_shift_norm #(
        .Width (P),
        .CntW  (CntW)
    ) u_norm (
        .clk      (clk),
        .rst      (rst),
        .load     (norm_load),
        .load_mag (abs_mag(x_q)),
        .en       (norm_en),
        .mag      (norm_mag),
        .cnt      (norm_cnt),
        .done     (norm_done)
    );

    // Next-state logic and normalizer controls.
    always_comb begin
        state_d   = state_q;
        norm_load = 1'b0;
        norm_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StAbs;
            end
            StAbs: begin
                norm_load = 1'b1;
                state_d   = (x_q == '0) ? StPack : StShift;
            end
            StShift: begin
                norm_en = 1'b1;
                if (norm_done) state_d = StPack;
            end
            StPack: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Pack sign, biased exponent and truncated mantissa; zero never produces -0.
    always_comb begin
        exp_full = ExpBase - {{(W + 1 - CntW){1'b0}}, norm_cnt};
        result   = zero_q ? ZeroFloat : {sign_q, exp_full[W-1:0], norm_mag[P-2:W]};
    end

    assign unused_bits = ^{exp_full[W], norm_mag[W-1:0]};

    // State, operand capture, and result/ready registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            x_q         <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            float_q     <= '0;
            shift_cnt_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_q == StPack);
            if (state_q == StIdle && bus.start) begin
                x_q <= bus.fixed;
            end
            if (state_q == StAbs) begin
                sign_q <= x_q[P-1];
                zero_q <= (x_q == '0);
            end
            if (state_q == StPack) begin
                float_q     <= result;
                shift_cnt_q <= norm_cnt;
            end
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.ready     = ready_q;
    assign bus.float     = float_q;
    assign bus.shift_cnt = shift_cnt_q;

endmodule
